// File: rtl/tw_horizontal_gen_pkg.sv
// Shared definitions for the Goldilocks twiddle burst generator.
package tw_horizontal_gen_pkg;

  localparam int unsigned TW_P_WIDTH   = 64;
  localparam logic [63:0] GOLDILOCKS_P   = 64'hFFFF_FFFF_0000_0001;
  localparam logic [31:0] GOLDILOCKS_EPS = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } tw_state_e;

  // Any 64-bit word is below 2p, so one conditional subtract makes it canonical.
  function automatic logic [63:0] gl_canon(input logic [63:0] x);
    return (x >= GOLDILOCKS_P) ? (x - GOLDILOCKS_P) : x;
  endfunction

  // Fold a 128-bit product using 2^64 = 2^32-1 and 2^96 = -1 (mod p).
  function automatic logic [63:0] gl_reduce(input logic [127:0] x);
    logic [65:0] s;
    logic [64:0] r;
    // + p keeps the subtraction of the top limb non-negative
    s = 66'(x[63:0]) + 66'(x[95:64]) * 66'(GOLDILOCKS_EPS)
      + 66'(GOLDILOCKS_P) - 66'(x[127:96]);
    r = 65'(s[63:0]) + 65'(s[65:64]) * 65'(GOLDILOCKS_EPS);
    if (r >= 65'(GOLDILOCKS_P)) r = r - 65'(GOLDILOCKS_P);
    return r[63:0];
  endfunction

endpackage

// File: rtl/tw_horizontal_gen_modmul_goldilocks.sv
// Pipelined 64x64 modular multiply over the Goldilocks prime, MUL_LAT stages.
module modmul_goldilocks
  import tw_horizontal_gen_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [TW_P_WIDTH-1:0] a,
  input  logic [TW_P_WIDTH-1:0] b,
  output logic                  out_valid,
  output logic [TW_P_WIDTH-1:0] result
);

  logic [127:0]          prod_q;
  logic                  prod_v_q;
  logic [TW_P_WIDTH-1:0] red_c;

  // Stage 1: raw product.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      prod_v_q <= in_valid;
      if (in_valid) prod_q <= 128'(a) * 128'(b);
    end
  end

  assign red_c = gl_reduce(prod_q);

  if (MUL_LAT < 2) begin : g_one
    assign result    = red_c;
    assign out_valid = prod_v_q;
  end else begin : g_pipe
    logic [TW_P_WIDTH-1:0] dly_q [MUL_LAT-1];
    logic                  dv_q  [MUL_LAT-1];

    // Remaining stages carry the reduced value and its valid bit.
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(MUL_LAT) - 1; i++) begin
          dly_q[i] <= '0;
          dv_q[i]  <= 1'b0;
        end
      end else begin
        dly_q[0] <= red_c;
        dv_q[0]  <= prod_v_q;
        for (int i = 1; i < int'(MUL_LAT) - 1; i++) begin
          dly_q[i] <= dly_q[i-1];
          dv_q[i]  <= dv_q[i-1];
        end
      end
    end

    assign result    = dly_q[MUL_LAT-2];
    assign out_valid = dv_q[MUL_LAT-2];
  end

endmodule

// File: rtl/tw_horizontal_gen.sv
// Twiddle burst generator: computes seed*step^k mod p and streams the words to ROM0.
// Build option: TW_GEN_BITREV_EN selects bit-reversed write order.
module tw_horizontal_gen
  import tw_horizontal_gen_pkg::*;
#(
  parameter int unsigned P_WIDTH = TW_P_WIDTH,
  parameter int unsigned NUM_TW  = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_WIDTH-1:0] seed,
  input  logic [P_WIDTH-1:0] step,
  output logic [P_WIDTH-1:0] horizontal_data_out,
  output logic               ROM0_w,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IDX_W = (NUM_TW > 2) ? $clog2(NUM_TW) : 1;

  tw_state_e          state_q, state_d;
  logic [P_WIDTH-1:0] tw_buf_q [NUM_TW];
  logic [P_WIDTH-1:0] tw_buf_d [NUM_TW];
  logic [P_WIDTH-1:0] acc_q, acc_d, step_q, step_d, data_q, data_d;
  logic [IDX_W-1:0]   k_q, k_d, wr_idx_q, wr_idx_d, rd_idx_c;
  logic               rom0_w_q, rom0_w_d, busy_q, busy_d, done_q, done_d;
  logic               mul_issue_c, mul_valid;
  logic [P_WIDTH-1:0] mul_res;

  modmul_goldilocks #(.MUL_LAT(MUL_LAT)) u_modmul (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .in_valid  (mul_issue_c),
    .a         (acc_q),
    .b         (step_q),
    .out_valid (mul_valid),
    .result    (mul_res)
  );

  // Buffer read index for the current write slot.
  always_comb begin
    rd_idx_c = wr_idx_q;
`ifdef TW_GEN_BITREV_EN
    for (int b = 0; b < int'(IDX_W); b++) rd_idx_c[b] = wr_idx_q[IDX_W-1-b];
`endif
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    tw_buf_d    = tw_buf_q;
    acc_d       = acc_q;
    step_d      = step_q;
    data_d      = data_q;
    k_d         = k_q;
    wr_idx_d    = wr_idx_q;
    busy_d      = busy_q;
    rom0_w_d    = 1'b0;
    done_d      = 1'b0;
    mul_issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d      = step;
          tw_buf_d[0] = P_WIDTH'(gl_canon(64'(seed)));
          acc_d       = P_WIDTH'(gl_canon(64'(seed)));
          k_d         = IDX_W'(1);
          busy_d      = 1'b1;
          state_d     = MUL;
        end
      end
      MUL: begin
        mul_issue_c = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // The valid bit emerges on the final of MUL_LAT wait cycles.
        if (mul_valid) begin
          tw_buf_d[k_q] = mul_res;
          acc_d         = mul_res;
          if (k_q == IDX_W'(NUM_TW - 1)) begin
            wr_idx_d = '0;
            state_d  = WR;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = MUL;
          end
        end
      end
      WR: begin
        rom0_w_d = 1'b1;
        data_d   = tw_buf_q[rd_idx_c];
        wr_idx_d = wr_idx_q + IDX_W'(1);
        if (wr_idx_q == IDX_W'(NUM_TW - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      for (int i = 0; i < int'(NUM_TW); i++) tw_buf_q[i] <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      data_q   <= '0;
      k_q      <= '0;
      wr_idx_q <= '0;
      rom0_w_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tw_buf_q <= tw_buf_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      data_q   <= data_d;
      k_q      <= k_d;
      wr_idx_q <= wr_idx_d;
      rom0_w_q <= rom0_w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign horizontal_data_out = data_q;
  assign ROM0_w              = rom0_w_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_tw_horizontal_gen.sv
// Randomised self-checking bench for tw_horizontal_gen against a modular-arithmetic model.
module tb_tw_horizontal_gen;

  localparam int unsigned P_WIDTH  = 64;
  localparam int unsigned NUM_TW   = 4;
  localparam int unsigned MUL_LAT  = 3;
  localparam logic [63:0] P        = 64'hFFFF_FFFF_0000_0001;
  localparam int          FIRST_WR = 1 + (NUM_TW - 1) * (MUL_LAT + 1);
  localparam int          IDXB     = $clog2(NUM_TW);

  logic               CLK = 1'b0;
  logic               rst_n, start;
  logic [P_WIDTH-1:0] seed, step;
  logic [P_WIDTH-1:0] horizontal_data_out;
  logic               ROM0_w, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  tw_horizontal_gen #(.P_WIDTH(P_WIDTH), .NUM_TW(NUM_TW), .MUL_LAT(MUL_LAT)) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .start               (start),
    .seed                (seed),
    .step                (step),
    .horizontal_data_out (horizontal_data_out),
    .ROM0_w              (ROM0_w),
    .busy                (busy),
    .done                (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pr;
    pr = (128'(a) * 128'(b)) % 128'(P);
    return pr[63:0];
  endfunction

  // Twiddle index emitted in write slot i.
  function automatic int slot_index(input int i);
    int r;
    r = i;
`ifdef TW_GEN_BITREV_EN
    r = 0;
    for (int b = 0; b < IDXB; b++) if (((i >> b) & 1) != 0) r |= 1 << (IDXB - 1 - b);
`endif
    return r;
  endfunction

  // seed * step^k mod p, with the power built independently of the product chain.
  function automatic logic [63:0] twiddle(input logic [63:0] s, input logic [63:0] st, input int k);
    logic [63:0] pw;
    logic [63:0] base;
    pw = 64'd1;
    for (int j = 0; j < k; j++) pw = mulmod(pw, st);
    base = 64'((128'(s)) % 128'(P));
    return mulmod(base, pw);
  endfunction

  // Launch one burst from the current (off-edge) time and check it up to done.
  task automatic run_burst(input logic [63:0] s, input logic [63:0] st, input bit disturb);
    logic [63:0] wq[$];
    int          we[$];
    int          done_e;
    bit          busy_ok;
    done_e  = -1;
    busy_ok = 1'b1;
    seed  = s;
    step  = st;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("busy_set", 64'(busy), 64'd1);
    for (int e = 1; e <= 60 && done_e < 0; e++) begin
      @(posedge CLK); #1;
      if (disturb && e == 2) begin
        start = 1'b1;
        seed  = {$urandom, $urandom};
        step  = {$urandom, $urandom};
      end
      if (disturb && e == 4) start = 1'b0;
      if (ROM0_w) begin
        wq.push_back(horizontal_data_out);
        we.push_back(e);
      end
      if (done) done_e = e;
      else if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check("done_edge", 64'(done_e), 64'(FIRST_WR + int'(NUM_TW)));
    check("busy_clr", 64'(busy), 64'd0);
    check("busy_hold", 64'(busy_ok), 64'd1);
    check("n_writes", 64'(wq.size()), 64'(NUM_TW));
    if (wq.size() > 0) begin
      check("first_wr_edge", 64'(we[0]), 64'(FIRST_WR));
      check("last_wr_edge", 64'(we[wq.size()-1]), 64'(FIRST_WR + int'(NUM_TW) - 1));
      check("data_hold", horizontal_data_out, wq[wq.size()-1]);
    end
    for (int i = 0; i < wq.size() && i < int'(NUM_TW); i++)
      check($sformatf("wr%0d", i), wq[i], twiddle(s, st, slot_index(i)));
  endtask

  // Watch for any strobe activity over n idle cycles.
  task automatic expect_quiet(input int n, input string tag);
    int strobes;
    strobes = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      if (ROM0_w || busy) strobes++;
    end
    check(tag, 64'(strobes), 64'd0);
  endtask

  initial begin
    logic [63:0] rs, rt;
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
    step  = '0;
    #12;
    check("rst_data", horizontal_data_out, 64'd0);
    check("rst_w", 64'(ROM0_w), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge CLK); rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed corner values.
    run_burst(64'd1, 64'd2, 1'b0);
    repeat (2) @(negedge CLK);
    run_burst(64'd1, 64'h1_0000_0000, 1'b0);
    repeat (2) @(negedge CLK);
    run_burst(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
    repeat (2) @(negedge CLK);
    run_burst(P, 64'd5, 1'b0);
    // Back-to-back: start in the done cycle.
    run_burst(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0);
    repeat (2) @(negedge CLK);

    // Mid-burst start and seed/step changes are ignored; no second burst.
    run_burst(64'd1, 64'd2, 1'b1);
    expect_quiet(30, "no_extra_burst");

    // Reset during write 2.
    @(negedge CLK);
    seed = 64'd7; step = 64'd9; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    for (int e = 1; e <= FIRST_WR + 2; e++) begin
      @(posedge CLK); #1;
    end
    check("pre_rst_w", 64'(ROM0_w), 64'd1);
    check("pre_rst_data", horizontal_data_out, twiddle(64'd7, 64'd9, slot_index(2)));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_w", 64'(ROM0_w), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_data", horizontal_data_out, 64'd0);
    @(negedge CLK); rst_n = 1'b1;
    expect_quiet(20, "post_rst_quiet");
    @(negedge CLK);
    run_burst(64'd7, 64'd9, 1'b0);

    // Randomised bursts, some back-to-back, some seeds at or above p.
    for (int i = 0; i < 10; i++) begin
      rs = {$urandom, $urandom};
      rt = {$urandom, $urandom};
      if (i % 3 == 0) rs = P + 64'($urandom_range(0, 1000));
      if (i % 4 == 1) rt = P - 64'($urandom_range(1, 3));
      if (i % 2 == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      run_burst(rs, rt, i % 5 == 2);
    end
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/tw_horizontal_gen.md
TW_HORIZONTAL_GEN -- requirements
Module: tw_horizontal_gen

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64, giving the data width.
REQ-002 SHALL have parameter NUM_TW, default 4, giving the number of twiddles per burst.
REQ-003 SHALL have parameter MUL_LAT, default 3, giving the modmul pipeline latency in cycles.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request for a new burst.
REQ-007 SHALL have port seed, input, P_WIDTH bits: first twiddle, w^0 of the group.
REQ-008 SHALL have port step, input, P_WIDTH bits: ratio between consecutive twiddles.
REQ-009 SHALL have port horizontal_data_out, output, P_WIDTH bits: twiddle word for the downstream ROM0 horizontal_data_in.
REQ-010 SHALL have port ROM0_w, output, 1 bit: write strobe to the downstream ROM0.
REQ-011 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last write.

Function
REQ-013 SHALL compute buf[k] = seed*step^k mod p for k=0..NUM_TW-1, where p = 0xFFFFFFFF00000001.
REQ-014 SHALL reduce seed to canonical [0,p) on capture, and all stored values SHALL be canonical.
REQ-015 SHALL have FSM states IDLE, MUL, WAIT, WR and DONE, reset to IDLE.
REQ-016 In IDLE with start=1, SHALL capture seed/step, set buf[0]=seed mod p, acc=buf[0], k=1, busy=1, and go to MUL.
REQ-017 In MUL, SHALL issue acc*step for one cycle, then go to WAIT.
REQ-018 In WAIT, SHALL spend MUL_LAT cycles; on the last cycle it SHALL store the result into buf[k] and acc, then go to WR if k=NUM_TW-1, else increment k and go to MUL.
REQ-019 ROM0_w SHALL be registered and SHALL first be high on the 1+(NUM_TW-1)*(MUL_LAT+1)th rising edge after the start-sampling edge (edge 13 for defaults).
REQ-020 In WR, ROM0_w SHALL be high for exactly NUM_TW consecutive cycles with no gaps, because the consumer index resets whenever the strobe drops.
REQ-021 In WR, horizontal_data_out SHALL carry buf[i] in the cycle where ROM0_w is high for write i.
REQ-022 In DONE, SHALL drive done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-023 start SHALL be ignored whenever the state is not IDLE, and seed/step changes mid-burst SHALL have no effect.
REQ-024 When ROM0_w=0, horizontal_data_out SHALL hold its previous value.
REQ-025 Back-to-back bursts: start asserted in the cycle after done SHALL be accepted.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE and clear ROM0_w, busy, done, k, acc, all buf entries and horizontal_data_out to 0.
REQ-027 rst_n low SHALL flush modmul pipeline valid bits, even mid-burst, with no partial strobe after release.

Configuration
REQ-028 With macro TW_GEN_BITREV_EN defined, the WR write order SHALL be bit-reversed over log2(NUM_TW) bits (0,2,1,3 for NUM_TW=4).
REQ-029 Without TW_GEN_BITREV_EN, the WR write order SHALL be natural (0,1,2,3), and all timing SHALL be identical in both builds.

Structure
REQ-030 Shared package SHALL hold the P_WIDTH default, modulus constant GOLDILOCKS_P, and the FSM state enum.
REQ-031 SHALL instantiate one sub-module, modmul_goldilocks: a MUL_LAT-stage 64x64 multiply with reduction using 2^64≡2^32-1 and 2^96≡-1, giving canonical output.
REQ-032 Target size: 150-300 lines of RTL total.

Verification
REQ-033 Scenario: seed=1, step=2 -> writes 1,2,4,8; ROM0_w high on edges 13-16; done on edge 17.
REQ-034 Scenario: seed=1, step=0x100000000 -> writes 1, 0x100000000, 0xFFFFFFFF, 0xFFFFFFFF00000000.
REQ-035 Scenario: seed=0xFFFFFFFF00000000, step=0xFFFFFFFF00000000 -> writes p-1, 1, p-1, 1; seed=p -> writes 0,0,0,0.
REQ-036 Scenario: start pulsed mid-burst and seed changed during WAIT -> output is unchanged versus an undisturbed run; no second burst occurs.
REQ-037 Scenario: rst_n dropped during WR write 2 -> ROM0_w=0 immediately; IDLE; a fresh start then gives a full 4-write burst.
REQ-038 Scenario: TW_GEN_BITREV_EN build, seed=1, step=2 -> writes 1,4,2,8 with identical strobe timing.
